// File: rtl/mem_req_buffer_pkg.sv
// Shared types and constants for the MEM request buffer.
package mem_req_buffer_pkg;

    // Sequencer states: idle/issuing, waiting for a response, or waiting
    // out a response that has already been answered by a timeout.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALE = 2'd2
    } state_t;

    // Fill bit for the read data returned with a timeout error response.
    localparam logic TIMEOUT_RDATA_BIT = 1'b0;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous FIFO holding queued MEM requests; head is read combinationally.
module mem_req_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; only control state is reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage, written on accepted push.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mem_req_buffer.sv
// MEM request buffer: queues upstream requests, issues them downstream one at
// a time and returns in-order responses, replacing a stuck response by an error.
module mem_req_buffer
    import mem_req_buffer_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        s_mem_req,
    input  logic [MEM_ADDR_WIDTH-1:0]   s_mem_addr,
    input  logic                        s_mem_we,
    input  logic [MEM_DATA_WIDTH-1:0]   s_mem_wdata,
    input  logic [MEM_DATA_WIDTH/8-1:0] s_mem_be,
    output logic                        s_mem_gnt,
    output logic                        s_mem_valid,
    output logic [MEM_DATA_WIDTH-1:0]   s_mem_rdata,
    output logic                        s_mem_error,
    output logic                        m_mem_req,
    output logic [MEM_ADDR_WIDTH-1:0]   m_mem_addr,
    output logic                        m_mem_we,
    output logic [MEM_DATA_WIDTH-1:0]   m_mem_wdata,
    output logic [MEM_DATA_WIDTH/8-1:0] m_mem_be,
    input  logic                        m_mem_gnt,
    input  logic                        m_mem_valid,
    input  logic [MEM_DATA_WIDTH-1:0]   m_mem_rdata,
    input  logic                        m_mem_error,
    output logic                        busy_o,
    output logic                        timeout_o
);

    localparam int BE_W    = MEM_DATA_WIDTH / 8;
    localparam int ENTRY_W = MEM_ADDR_WIDTH + 1 + MEM_DATA_WIDTH + BE_W;
    localparam int CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               rsp_take;
    logic               tmo_fire;

    logic                      rsp_vld_p1;
    logic [MEM_DATA_WIDTH-1:0] rsp_rdata_p1;
    logic                      rsp_err_p1;
    logic                      tmo_sticky;

    // Accept path: grant uses the registered full flag only, never a pop bypass.
    assign s_mem_gnt  = s_mem_req & ~fifo_full;
    assign fifo_push  = s_mem_req & s_mem_gnt;
    assign fifo_wdata = {s_mem_addr, s_mem_we, s_mem_wdata, s_mem_be};

    mem_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Downstream fields come straight from the FIFO head, so they stay stable
    // while the request waits for a grant.
    assign {m_mem_addr, m_mem_we, m_mem_wdata, m_mem_be} = fifo_rdata;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state, downstream request and response/timeout decisions.
    always_comb begin
        state_d   = state_q;
        m_mem_req = 1'b0;
        fifo_pop  = 1'b0;
        rsp_take  = 1'b0;
        tmo_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                m_mem_req = ~fifo_empty;
                if (~fifo_empty && m_mem_gnt) begin
                    fifo_pop = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // A real response in the expiry cycle takes precedence.
                if (m_mem_valid) begin
                    rsp_take = 1'b1;
                    state_d  = IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    tmo_fire = 1'b1;
                    state_d  = STALE;
                end
            end
            STALE: begin
                // Late response already answered by the timeout: drop it.
                if (m_mem_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Wait-cycle counter: cleared on issue, saturating while waiting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (fifo_pop) begin
            cnt_q <= '0;
        end else if ((state_q == WAIT) && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // ---- stage p1: registered upstream response ----
    // Response register: real response data or a zero-data timeout error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_vld_p1   <= 1'b0;
            rsp_rdata_p1 <= '0;
            rsp_err_p1   <= 1'b0;
        end else begin
            rsp_vld_p1 <= rsp_take | tmo_fire;
            if (rsp_take) begin
                rsp_rdata_p1 <= m_mem_rdata;
                rsp_err_p1   <= m_mem_error;
            end else if (tmo_fire) begin
                rsp_rdata_p1 <= {MEM_DATA_WIDTH{TIMEOUT_RDATA_BIT}};
                rsp_err_p1   <= 1'b1;
            end
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)         tmo_sticky <= 1'b0;
        else if (tmo_fire) tmo_sticky <= 1'b1;
    end

    assign s_mem_valid = rsp_vld_p1;
    assign s_mem_rdata = rsp_rdata_p1;
    assign s_mem_error = rsp_err_p1;
    assign timeout_o   = tmo_sticky;
    assign busy_o      = ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_mem_req_buffer.sv
// Self-checking bench for mem_req_buffer against a transaction-level model.
module tb_mem_req_buffer;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int DEP  = 4;
    localparam int TMO  = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } req_t;

    typedef struct packed {
        int            due;
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } rsp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          s_mem_req = 1'b0;
    logic [AW-1:0] s_mem_addr = '0;
    logic          s_mem_we = 1'b0;
    logic [DW-1:0] s_mem_wdata = '0;
    logic [BW-1:0] s_mem_be = '0;
    logic          s_mem_gnt;
    logic          s_mem_valid;
    logic [DW-1:0] s_mem_rdata;
    logic          s_mem_error;
    logic          m_mem_req;
    logic [AW-1:0] m_mem_addr;
    logic          m_mem_we;
    logic [DW-1:0] m_mem_wdata;
    logic [BW-1:0] m_mem_be;
    logic          m_mem_gnt = 1'b0;
    logic          m_mem_valid = 1'b0;
    logic [DW-1:0] m_mem_rdata = '0;
    logic          m_mem_error = 1'b0;
    logic          busy_o;
    logic          timeout_o;

    mem_req_buffer #(
        .MEM_ADDR_WIDTH (AW),
        .MEM_DATA_WIDTH (DW),
        .DEPTH          (DEP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .s_mem_req   (s_mem_req),
        .s_mem_addr  (s_mem_addr),
        .s_mem_we    (s_mem_we),
        .s_mem_wdata (s_mem_wdata),
        .s_mem_be    (s_mem_be),
        .s_mem_gnt   (s_mem_gnt),
        .s_mem_valid (s_mem_valid),
        .s_mem_rdata (s_mem_rdata),
        .s_mem_error (s_mem_error),
        .m_mem_req   (m_mem_req),
        .m_mem_addr  (m_mem_addr),
        .m_mem_we    (m_mem_we),
        .m_mem_wdata (m_mem_wdata),
        .m_mem_be    (m_mem_be),
        .m_mem_gnt   (m_mem_gnt),
        .m_mem_valid (m_mem_valid),
        .m_mem_rdata (m_mem_rdata),
        .m_mem_error (m_mem_error),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: accepted-but-unissued requests, scheduled responses.
    req_t q[$];
    rsp_t ev[$];
    req_t pend_r;
    bit   pend = 0;
    int   cyc = 0;
    int   ready_cyc = 0;    // first cycle the buffer may issue again
    int   valid_due = -1;   // cycle the downstream responder drives m_mem_valid
    logic [DW-1:0] v_rdata = '0;
    logic          v_err = 1'b0;
    bit   tmo_exp = 0;

    // Stimulus controls.
    bit   gen_en = 0;
    int   req_pct = 40;
    int   gnt_mode = 1;     // 0 low, 1 high, 2 random
    int   forced_d = 0;
    logic [DW-1:0] forced_rd = '0;
    logic          forced_err = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic queue_req(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd, input logic [BW-1:0] be);
        pend_r = '{addr: a, we: we, wdata: wd, be: be};
        pend   = 1;
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance the model.
    task automatic step();
        bit   exp_full;
        bit   exp_req;
        bit   exp_vld;
        rsp_t e;
        req_t h;
        int   d;
        int   r;
        logic [DW-1:0] rd;
        logic er;
        @(negedge clk_i);
        cyc++;
        rst_i = 1'b0;
        if (!pend && gen_en && ($urandom_range(0, 99) < req_pct))
            queue_req($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        s_mem_req   = pend;
        s_mem_addr  = pend_r.addr;
        s_mem_we    = pend_r.we;
        s_mem_wdata = pend_r.wdata;
        s_mem_be    = pend_r.be;
        case (gnt_mode)
            0:       m_mem_gnt = 1'b0;
            1:       m_mem_gnt = 1'b1;
            default: m_mem_gnt = 1'($urandom_range(0, 1));
        endcase
        m_mem_valid = (cyc == valid_due);
        m_mem_rdata = m_mem_valid ? v_rdata : $urandom;
        m_mem_error = m_mem_valid ? v_err : 1'($urandom_range(0, 1));
        #1;
        exp_full = (q.size() >= DEP);
        check_val("s_gnt", s_mem_gnt, pend && !exp_full);
        exp_req = (cyc >= ready_cyc) && (q.size() > 0);
        check_val("m_req", m_mem_req, exp_req);
        if (exp_req) begin
            h = q[0];
            check_val("m_addr", m_mem_addr, h.addr);
            check_val("m_we", m_mem_we, h.we);
            check_val("m_wdata", m_mem_wdata, h.wdata);
            check_val("m_be", m_mem_be, h.be);
        end
        exp_vld = 0;
        if (ev.size() > 0 && ev[0].due == cyc) begin
            exp_vld = 1;
            e = ev.pop_front();
            if (e.tmo) tmo_exp = 1;
        end
        check_val("s_valid", s_mem_valid, exp_vld);
        if (exp_vld) begin
            check_val("s_rdata", s_mem_rdata, e.rdata);
            check_val("s_error", s_mem_error, e.err);
        end
        check_val("busy", busy_o, (q.size() > 0) || (cyc < ready_cyc));
        check_val("timeout", timeout_o, tmo_exp);
        // Advance model across the rising edge.
        if (pend && !exp_full) begin
            q.push_back(pend_r);
            pend = 0;
        end
        if (exp_req && m_mem_gnt) begin
            void'(q.pop_front());
            if (forced_d > 0) begin
                d = forced_d; rd = forced_rd; er = forced_err; forced_d = 0;
            end else begin
                r = $urandom_range(0, 9);
                if (r <= 6)      d = $urandom_range(1, 4);
                else if (r == 7) d = TMO;
                else if (r == 8) d = $urandom_range(TMO + 1, TMO + 4);
                else             d = $urandom_range(5, TMO - 1);
                rd = $urandom;
                er = ($urandom_range(0, 7) == 0);
            end
            valid_due = cyc + d;
            ready_cyc = cyc + d + 1;
            v_rdata = rd;
            v_err   = er;
            if (d <= TMO) ev.push_back('{due: cyc + d + 1, rdata: rd, err: er, tmo: 1'b0});
            else          ev.push_back('{due: cyc + TMO + 1, rdata: '0, err: 1'b1, tmo: 1'b1});
        end
    endtask

    // One reset cycle; the pending downstream response (if any) is left to arrive.
    task automatic do_reset();
        @(negedge clk_i);
        cyc++;
        rst_i       = 1'b1;
        s_mem_req   = 1'b0;
        m_mem_gnt   = 1'b0;
        m_mem_valid = (cyc == valid_due);
        m_mem_rdata = v_rdata;
        m_mem_error = v_err;
        q.delete();
        ev.delete();
        pend      = 0;
        ready_cyc = 0;
        tmo_exp   = 0;
    endtask

    task automatic step_until_accepted(input string tag);
        int n = 0;
        while (pend && n < 50) begin step(); n++; end
        if (pend) check_val({tag, "_accept_timeout"}, 1, 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(q.size() == 0 && !pend && ev.size() == 0 && cyc >= ready_cyc) && n < 400) begin
            step(); n++;
        end
        if (n >= 400) check_val({tag, "_drain_timeout"}, 1, 0);
    endtask

    initial begin
        do_reset();
        do_reset();
        step();
        check_val("rst_rdata", s_mem_rdata, 0);
        check_val("rst_error", s_mem_error, 0);

        // Single read with a two-cycle downstream latency.
        gnt_mode = 1;
        forced_d = 2; forced_rd = 32'hCAFEBABE; forced_err = 1'b0;
        queue_req(32'h1000, 1'b0, '0, 4'hF);
        drain("single");

        // Downstream error passthrough.
        forced_d = 3; forced_rd = 32'h0BAD0BAD; forced_err = 1'b1;
        queue_req(32'h2000, 1'b0, '0, 4'hF);
        drain("err");

        // Burst fill with grant held low; fifth request must stall.
        gnt_mode = 0;
        for (int i = 0; i < 4; i++) begin
            queue_req(32'(i * 4), 1'b1, $urandom, 4'hF);
            step_until_accepted("burst");
        end
        queue_req(32'h10, 1'b1, $urandom, 4'hF);
        repeat (3) step();
        check_val("burst_full_gnt", s_mem_gnt, 0);
        gnt_mode = 1;
        drain("burst");

        // Response arriving exactly in the expiry cycle wins.
        forced_d = TMO; forced_rd = 32'hA5A5A5A5; forced_err = 1'b0;
        queue_req(32'h3000, 1'b0, '0, 4'hF);
        drain("simul");
        check_val("simul_no_timeout", timeout_o, 0);

        // Timeout followed by a late response and a second request.
        forced_d = TMO + 12; forced_rd = 32'h12345678; forced_err = 1'b0;
        queue_req(32'h4000, 1'b0, '0, 4'hF);
        step_until_accepted("tmo");
        queue_req(32'h4004, 1'b0, '0, 4'hF);
        drain("tmo");
        check_val("tmo_sticky", timeout_o, 1);

        // Reset during WAIT with three queued requests.
        forced_d = 6; forced_rd = 32'h77777777; forced_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            queue_req(32'h5000 + 32'(i * 4), 1'b0, '0, 4'hF);
            step_until_accepted("flush");
        end
        do_reset();
        step();
        check_val("flush_busy", busy_o, 0);
        check_val("flush_mreq", m_mem_req, 0);
        check_val("flush_rdata", s_mem_rdata, 0);
        repeat (10) step();
        drain("flush");

        // Randomised traffic.
        gen_en = 1;
        gnt_mode = 2;
        repeat (1500) step();
        gen_en = 0;
        gnt_mode = 1;
        drain("random");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
